// File: rtl/cache_pkg.sv
// Shared definitions for the L1 cache controller replacement logic.
package cache_pkg;

    typedef enum logic {
        INIT,
        RUN
    } repl_state_e;

    localparam int unsigned MAX_WAYS = 16;
    localparam int unsigned MAX_SETS = 1024;

    // Tree-PLRU needs one decision bit per internal node of a full binary tree.
    function automatic int unsigned plru_nodes(input int unsigned ways);
        return ways - 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU helpers: victim walk / invalid-way priority, and
// the next tree bits after touching a way.
module plru_tree
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = 4
) (
    input  logic [plru_nodes(WAYS)-1:0] tree_i,
    input  logic [WAYS-1:0]             way_valid_i,
    input  logic [$clog2(WAYS)-1:0]     touch_way_i,
    output logic [$clog2(WAYS)-1:0]     victim_way_o,
    output logic [plru_nodes(WAYS)-1:0] tree_o
);

    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned NODES = plru_nodes(WAYS);

    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] walk;

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!way_valid_i[i] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
        end
    end

    // Level l holds nodes (2^l - 1) .. (2^(l+1) - 2); the node on the path is
    // selected by the way-index prefix already decided at the upper levels.
    always_comb begin
        walk = '0;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            for (int unsigned p = 0; p < (32'd1 << l); p++) begin
                if ((32'(walk) >> (WAY_W - l)) == p) begin
                    walk[WAY_W-1-l] = tree_i[(32'd1 << l) - 1 + p];
                end
            end
        end
        victim_way_o = inv_found ? inv_way : walk;
    end

    always_comb begin
        tree_o = tree_i;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            for (int unsigned p = 0; p < (32'd1 << l); p++) begin
                if ((32'(touch_way_i) >> (WAY_W - l)) == p) begin
                    tree_o[(32'd1 << l) - 1 + p] = ~touch_way_i[WAY_W-1-l];
                end
            end
        end
    end

    logic unused_nodes;
    assign unused_nodes = (NODES == 0);

endmodule

// File: rtl/plru_repl.sv
// Tree pseudo-LRU replacement engine: per-set tree bits, touch updates,
// registered victim selection and self-initialisation after reset/flush.
module plru_repl
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    output logic                    busy_o,
    input  logic                    touch_valid_i,
    input  logic [$clog2(SETS)-1:0] touch_set_i,
    input  logic [$clog2(WAYS)-1:0] touch_way_i,
    input  logic                    victim_req_i,
    input  logic [$clog2(SETS)-1:0] victim_set_i,
    input  logic [WAYS-1:0]         way_valid_i,
    output logic                    victim_valid_o,
    output logic [$clog2(WAYS)-1:0] victim_way_o
);

    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned SET_W = $clog2(SETS);
    localparam int unsigned NODES = plru_nodes(WAYS);

    if (WAYS < 2 || WAYS > MAX_WAYS || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
        $error("plru_repl: WAYS must be a power of two in 2..16");
    end
    if (SETS < 2 || SETS > MAX_SETS || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
        $error("plru_repl: SETS must be a power of two in 2..1024");
    end

    repl_state_e      state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic [NODES-1:0] tree_q [SETS];
    logic             victim_valid_q;
    logic [WAY_W-1:0] victim_way_q;

    logic [NODES-1:0] touch_tree_next;
    logic [WAY_W-1:0] victim_way_sel;
    logic [WAY_W-1:0] unused_touch_victim;
    logic [NODES-1:0] unused_victim_tree;

    logic running;
    assign running = (state_q == RUN);

    plru_tree #(.WAYS(WAYS)) u_victim_tree (
        .tree_i       (tree_q[victim_set_i]),
        .way_valid_i  (way_valid_i),
        .touch_way_i  ('0),
        .victim_way_o (victim_way_sel),
        .tree_o       (unused_victim_tree)
    );

    plru_tree #(.WAYS(WAYS)) u_touch_tree (
        .tree_i       (tree_q[touch_set_i]),
        .way_valid_i  ('1),
        .touch_way_i  (touch_way_i),
        .victim_way_o (unused_touch_victim),
        .tree_o       (touch_tree_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                if (flush_i) begin
                    cnt_d = '0;
                end else if (cnt_q == SET_W'(SETS - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SET_W'(1);
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= INIT;
            cnt_q          <= '0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            victim_valid_q <= running && victim_req_i;
            if (running && victim_req_i) begin
                victim_way_q <= victim_way_sel;
            end
        end
    end

    // No reset on the array: INIT clears it one set per cycle. A flush drops a
    // same-cycle touch since the whole array is about to be rewritten.
    always_ff @(posedge clk_i) begin
        if (!running) begin
            tree_q[cnt_q] <= '0;
        end else if (touch_valid_i && !flush_i) begin
            tree_q[touch_set_i] <= touch_tree_next;
        end
    end

    assign busy_o         = (state_q == INIT);
    assign victim_valid_o = victim_valid_q;
    assign victim_way_o   = victim_way_q;

endmodule

// File: tb/tb_plru_repl.sv
// Randomized bench for plru_repl against a last-touch-timestamp PLRU model.
module tb_plru_repl;

    localparam int unsigned WAYS  = 8;
    localparam int unsigned SETS  = 128;
    localparam int unsigned WAY_W = 3;
    localparam int unsigned SET_W = 7;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             busy_o;
    logic             touch_valid_i;
    logic [SET_W-1:0] touch_set_i;
    logic [WAY_W-1:0] touch_way_i;
    logic             victim_req_i;
    logic [SET_W-1:0] victim_set_i;
    logic [WAYS-1:0]  way_valid_i;
    logic             victim_valid_o;
    logic [WAY_W-1:0] victim_way_o;

    plru_repl #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .touch_valid_i  (touch_valid_i),
        .touch_set_i    (touch_set_i),
        .touch_way_i    (touch_way_i),
        .victim_req_i   (victim_req_i),
        .victim_set_i   (victim_set_i),
        .way_valid_i    (way_valid_i),
        .victim_valid_o (victim_valid_o),
        .victim_way_o   (victim_way_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: each way remembers when it was last touched (0 = never). A tree
    // node's LRU side is the half whose most recent touch is older (ties: left).
    int unsigned stamp [SETS][WAYS];
    int unsigned now_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int unsigned s = 0; s < SETS; s++)
            for (int unsigned w = 0; w < WAYS; w++)
                stamp[s][w] = 0;
    endfunction

    function automatic void model_touch(input int unsigned s, input int unsigned w);
        now_t++;
        stamp[s][w] = now_t;
    endfunction

    function automatic int unsigned model_victim(input int unsigned s, input logic [WAYS-1:0] vld);
        int unsigned lo, size, half, ml, mr;
        for (int unsigned i = 0; i < WAYS; i++)
            if (!vld[i]) return i;
        lo = 0;
        size = WAYS;
        while (size > 1) begin
            half = size / 2;
            ml = 0;
            mr = 0;
            for (int unsigned j = 0; j < half; j++) begin
                if (stamp[s][lo + j] > ml) ml = stamp[s][lo + j];
                if (stamp[s][lo + half + j] > mr) mr = stamp[s][lo + half + j];
            end
            if (ml > mr) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    task automatic idle_inputs();
        flush_i       = 1'b0;
        touch_valid_i = 1'b0;
        touch_set_i   = '0;
        touch_way_i   = '0;
        victim_req_i  = 1'b0;
        victim_set_i  = '0;
        way_valid_i   = '1;
    endtask

    // One clock of stimulus in RUN; checks the registered victim response.
    task automatic step(input bit tv, input int unsigned ts, input int unsigned tw,
                        input bit rq, input int unsigned vs, input logic [WAYS-1:0] vv,
                        input bit fl);
        int unsigned exp_way;
        touch_valid_i = tv;
        touch_set_i   = SET_W'(ts);
        touch_way_i   = WAY_W'(tw);
        victim_req_i  = rq;
        victim_set_i  = SET_W'(vs);
        way_valid_i   = vv;
        flush_i       = fl;
        exp_way = model_victim(vs, vv);
        @(posedge clk);
        #1;
        if (fl) model_clear();
        else if (tv) model_touch(ts, tw);
        idle_inputs();
        chk("victim_valid", 32'(victim_valid_o), 32'(rq));
        if (rq) chk("victim_way", 32'(victim_way_o), exp_way);
    endtask

    // Edges during initialisation: busy must hold until the SETS-th edge and
    // requests must be ignored.
    task automatic init_window(input int unsigned n_edges, input string tag);
        for (int unsigned k = 1; k <= n_edges; k++) begin
            victim_req_i  = 1'b1;
            victim_set_i  = SET_W'($urandom);
            touch_valid_i = 1'b1;
            touch_set_i   = SET_W'($urandom);
            touch_way_i   = WAY_W'($urandom);
            @(posedge clk);
            #1;
            chk(tag, 32'(busy_o), 32'(k < SETS));
            chk("init_no_victim", 32'(victim_valid_o), 32'd0);
        end
        idle_inputs();
    endtask

    initial begin
        int unsigned ts, tw, vs;
        logic [WAYS-1:0] vv;
        idle_inputs();
        rst_ni = 1'b0;
        now_t  = 0;
        model_clear();
        #2;
        chk("reset_busy", 32'(busy_o), 32'd1);
        chk("reset_valid", 32'(victim_valid_o), 32'd0);
        chk("reset_way", 32'(victim_way_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        init_window(SETS, "busy_after_reset");

        // Fresh tree, then LRU after touching every way in order.
        step(0, 0, 0, 1, 5, '1, 0);
        chk("fresh_set5", 32'(victim_way_o), 32'd0);
        for (int unsigned w = 0; w < WAYS; w++) step(1, 5, w, 0, 0, '1, 0);
        step(0, 0, 0, 1, 5, '1, 0);
        chk("lru_set5", 32'(victim_way_o), 32'd0);

        // Invalid way beats the tree.
        step(1, 9, 5, 0, 0, '1, 0);
        step(1, 9, 1, 0, 0, '1, 0);
        step(0, 0, 0, 1, 9, 8'b1111_1011, 0);
        chk("invalid_way2", 32'(victim_way_o), 32'd2);

        // Same-cycle touch and request see the pre-touch tree.
        step(1, 3, 0, 0, 0, '1, 0);
        step(1, 3, 4, 1, 3, '1, 0);
        chk("pretouch_set3", 32'(victim_way_o), 32'd4);
        step(0, 0, 0, 1, 3, '1, 0);
        chk("posttouch_set3", 32'(victim_way_o), 32'd2);

        // Flush with a same-cycle touch, re-flush during INIT.
        step(1, 7, 0, 0, 0, '1, 0);
        step(1, 7, 3, 0, 0, '1, 0);
        step(1, 7, 5, 0, 0, '1, 0);
        step(1, 7, 1, 0, 0, '1, 1);
        chk("flush_busy", 32'(busy_o), 32'd1);
        init_window(50, "busy_after_flush");
        step(0, 0, 0, 0, 0, '1, 1);
        init_window(SETS, "busy_after_reflush");
        step(0, 0, 0, 1, 7, '1, 0);
        chk("flushed_set7", 32'(victim_way_o), 32'd0);

        // Randomized traffic, biased towards a few sets to create collisions.
        for (int unsigned n = 0; n < 4000; n++) begin
            ts = ($urandom % 4 == 0) ? $urandom % SETS : $urandom % 4;
            vs = ($urandom % 4 == 0) ? $urandom % SETS : $urandom % 4;
            tw = $urandom % WAYS;
            vv = ($urandom % 4 == 0) ? WAYS'($urandom) : '1;
            step(1'($urandom), ts, tw, 1'($urandom), vs, vv, 0);
        end

        // Back-to-back requests, then asynchronous reset kills the pending pulse.
        step(0, 0, 0, 1, 1, '1, 0);
        step(0, 0, 0, 1, 2, '1, 0);
        step(0, 0, 0, 1, 3, '1, 0);
        step(0, 0, 0, 1, 1, '1, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_reset_valid", 32'(victim_valid_o), 32'd0);
        chk("async_reset_busy", 32'(busy_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
